// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
//   fetch_state_e : controller FSM states
//   fetch_entry_t : one fetch buffer entry {instr, pc}
//   DEF_*         : default parameter values
package fetch_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned ENTRY_W  = INSTR_W + ADDR_W;

  localparam int unsigned          DEF_MEM_SIZE = 1024;
  localparam logic [ADDR_W-1:0]    DEF_RESET_PC = 64'd0;
  localparam int unsigned          DEF_DEPTH    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO of {instr, pc}.
//   clk, rst_n   : clock, async active-low reset
//   push / wdata : enqueue (accepted when not full, or when popping the same cycle)
//   pop  / rdata : dequeue head; rdata is the current head
//   flush        : empty the buffer; overrides push and pop
//   full, empty  : occupancy flags
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty && !flush;
  // A full buffer can still take a write when the head leaves this cycle.
  assign do_push = push && (!full || do_pop) && !flush;
  assign rdata   = mem[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a pc through a combinational ROM,
// buffers {instr, pc} pairs for decode, handles redirects and fetch faults.
//   clk, reset             : clock, async active-low reset
//   start                  : leave IDLE and begin fetching
//   imem_addr / imem_instr : ROM address (pc) and same-cycle read data
//   redirect, redirect_pc  : taken branch; flush buffer and refetch at target
//   out_valid/ready/instr/pc : buffer head handshake to decode
//   fault                  : sticky fetch fault (misaligned target or out of ROM)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned       MEM_SIZE = DEF_MEM_SIZE,
  parameter logic [63:0]       RESET_PC = DEF_RESET_PC,
  parameter int unsigned       DEPTH    = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_instr,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [ADDR_W-1:0]   out_pc,
  output logic                fault
);

  // Highest address at which a whole 4-byte word still fits in the ROM.
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_SIZE - 32'd4);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic              push, pop, flush;
  logic              fifo_full, fifo_empty;
  logic              deq;
  logic              pc_oob;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign imem_addr  = pc_q;
  assign fault      = fault_q;
  assign out_valid  = !fifo_empty;
  assign out_instr  = head.instr;
  assign out_pc     = head.pc;
  assign deq        = out_valid && out_ready;
  // pc is always word-aligned, so pc+3 < MEM_SIZE reduces to pc <= LAST_WORD.
  assign pc_oob     = (pc_q > LAST_WORD);
  assign push_entry = '{instr: imem_instr, pc: pc_q};

  // State, pc and sticky fault registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  // Next state, pc update and buffer control.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        pop = deq;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          // Redirect wins over push and pop; a bad target faults without moving pc.
          flush = 1'b1;
          if (redirect_pc[1:0] != 2'b00) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            pc_d = redirect_pc;
          end
        end else begin
          pop = deq;
          if (!fifo_full || deq) begin
            if (pc_oob) begin
              state_d = FAULT;
              fault_d = 1'b1;
            end else begin
              push = 1'b1;
              pc_d = pc_q + 64'd4;
            end
          end
        end
      end
      FAULT: begin
        pop = deq;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a queue-based reference model.
module tb_fetch_ctrl;

  localparam int unsigned MEM_SIZE = 1024;
  localparam int unsigned DEPTH    = 2;
  localparam logic [63:0] RESET_PC = 64'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        fault;

  int nvec = 0;
  int nerr = 0;

  // Reference model: mode 0 idle, 1 fetching, 2 faulted; buffer as a queue of pcs.
  int          m_mode;
  logic [63:0] m_pc;
  logic        m_fault;
  logic [63:0] m_q[$];

  fetch_ctrl #(
    .MEM_SIZE (MEM_SIZE),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .fault       (fault)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [63:0] a);
    return 32'h1357_9BDF ^ (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  assign imem_instr = rom(imem_addr);

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = RESET_PC;
    m_fault = 1'b0;
    m_q.delete();
  endtask

  // Advances the model by one clock edge from the current inputs.
  task automatic model_step();
    bit popped;
    if (!reset) begin
      model_reset();
      return;
    end
    popped = (m_q.size() != 0) && out_ready;
    case (m_mode)
      0: begin
        if (popped) void'(m_q.pop_front());
        if (start) m_mode = 1;
      end
      1: begin
        if (redirect) begin
          m_q.delete();
          if (redirect_pc % 4 != 0) begin
            m_mode = 2; m_fault = 1'b1;
          end else begin
            m_pc = redirect_pc;
          end
        end else begin
          if (popped) void'(m_q.pop_front());
          if (m_q.size() < DEPTH) begin
            if (m_pc + 3 >= 64'(MEM_SIZE)) begin
              m_mode = 2; m_fault = 1'b1;
            end else begin
              m_q.push_back(m_pc);
              m_pc = m_pc + 4;
            end
          end
        end
      end
      default: begin
        if (popped) void'(m_q.pop_front());
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; redirect = 1'b0; out_ready = 1'b0; redirect_pc = '0;
    model_reset();
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    nvec++; if (fault !== 1'b0) begin nerr++; $display("FAIL reset_fault got %b exp 0", fault); end
    nvec++; if (imem_addr !== RESET_PC) begin nerr++; $display("FAIL reset_addr got %h exp %h", imem_addr, RESET_PC); end
    // Redirect and pops are ignored in IDLE.
    redirect = 1'b1; redirect_pc = 64'h80; out_ready = 1'b1;
    repeat (3) tick();
    nvec++; if (imem_addr !== m_pc) begin nerr++; $display("FAIL idle_redirect got %h exp %h", imem_addr, m_pc); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL idle_valid got %b exp 0", out_valid); end
    // Start together with redirect: start wins, pc unchanged.
    start = 1'b1;
    tick();
    start = 1'b0; redirect = 1'b0;
    nvec++; if (imem_addr !== 64'h0) begin nerr++; $display("FAIL start_redirect_addr got %h exp 0", imem_addr); end
    tick();
    nvec++; if (out_valid !== 1'b1 || out_pc !== 64'h0) begin nerr++; $display("FAIL start_first got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      nvec++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instr !== rom(64'(4 * k))) begin
        nerr++;
        $display("FAIL stream[%0d] got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h",
                 k, out_valid, out_pc, out_instr, 64'(4 * k), rom(64'(4 * k)));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    nvec++; if (imem_addr !== 64'h8) begin nerr++; $display("FAIL stall_addr got %h exp 8", imem_addr); end
    nvec++; if (out_valid !== 1'b1 || out_pc !== 64'h0) begin nerr++; $display("FAIL stall_head got v=%b pc=%h exp v=1 pc=0", out_valid, out_pc); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (out_valid !== 1'b1 || out_pc !== 64'(4 * k)) begin
        nerr++; $display("FAIL release[%0d] got v=%b pc=%h exp v=1 pc=%h", k, out_valid, out_pc, 64'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    nvec++; if (m_q.size() != DEPTH || out_valid !== 1'b1) begin nerr++; $display("FAIL full_setup got v=%b exp buffer full", out_valid); end
    redirect = 1'b1; redirect_pc = 64'h40;
    tick();
    redirect = 1'b0; out_ready = 1'b1;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL redir_flush got %b exp 0", out_valid); end
    nvec++; if (imem_addr !== 64'h40) begin nerr++; $display("FAIL redir_addr got %h exp 40", imem_addr); end
    tick();
    nvec++; if (out_valid !== 1'b1 || out_pc !== 64'h40) begin nerr++; $display("FAIL redir_first got v=%b pc=%h exp 40", out_valid, out_pc); end
    tick();
    nvec++; if (out_valid !== 1'b1 || out_pc !== 64'h44) begin nerr++; $display("FAIL redir_second got v=%b pc=%h exp 44", out_valid, out_pc); end
  endtask

  task automatic test_misaligned();
    logic [63:0] held;
    do_reset();
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    held = m_pc;
    redirect = 1'b1; redirect_pc = 64'h42;
    tick();
    redirect = 1'b0;
    nvec++; if (fault !== 1'b1) begin nerr++; $display("FAIL misalign_fault got %b exp 1", fault); end
    nvec++; if (imem_addr !== held) begin nerr++; $display("FAIL misalign_pc got %h exp %h", imem_addr, held); end
    // Redirect and start are ignored in FAULT.
    redirect = 1'b1; redirect_pc = 64'h100; start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      nvec++;
      if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== held) begin
        nerr++; $display("FAIL fault_hold[%0d] got f=%b v=%b a=%h exp f=1 v=0 a=%h", k, fault, out_valid, imem_addr, held);
      end
    end
    redirect = 1'b0; start = 1'b0;
  endtask

  task automatic test_oob();
    do_reset();
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h3FC;
    tick();
    redirect = 1'b0;
    tick();
    nvec++; if (out_valid !== 1'b1 || out_pc !== 64'h3FC || fault !== 1'b0) begin nerr++; $display("FAIL oob_last got v=%b pc=%h f=%b exp v=1 pc=3fc f=0", out_valid, out_pc, fault); end
    tick();
    nvec++; if (fault !== 1'b1) begin nerr++; $display("FAIL oob_fault got %b exp 1", fault); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL oob_nopush got %b exp 0", out_valid); end
    nvec++; if (imem_addr !== 64'h400) begin nerr++; $display("FAIL oob_addr got %h exp 400", imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b0; model_reset();
    #1;
    nvec++; if (out_valid !== 1'b0 || imem_addr !== RESET_PC) begin nerr++; $display("FAIL midreset_run got v=%b a=%h exp v=0 a=%h", out_valid, imem_addr, RESET_PC); end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    redirect = 1'b1; redirect_pc = 64'h43;
    tick();
    redirect = 1'b0;
    nvec++; if (fault !== 1'b1) begin nerr++; $display("FAIL midreset_setup got %b exp 1", fault); end
    #2 reset = 1'b0; model_reset();
    #1;
    nvec++; if (fault !== 1'b0 || out_valid !== 1'b0 || imem_addr !== RESET_PC) begin nerr++; $display("FAIL midreset_fault got f=%b v=%b a=%h exp 0 0 %h", fault, out_valid, imem_addr, RESET_PC); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    start = 1'b1;
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect  = ($urandom_range(0, 9) == 0);
      redirect_pc = {52'h0, 8'($urandom_range(0, 250)), 2'b00};
      if (c == 580) begin redirect = 1'b1; redirect_pc = 64'h1F2; end
      if ($urandom_range(0, 7) == 0) start = ~start;
      tick();
      nvec++;
      if (out_valid !== (m_q.size() != 0)) begin nerr++; $display("FAIL rnd_valid[%0d] got %b exp %b", c, out_valid, m_q.size() != 0); end
      nvec++;
      if (imem_addr !== m_pc) begin nerr++; $display("FAIL rnd_addr[%0d] got %h exp %h", c, imem_addr, m_pc); end
      nvec++;
      if (fault !== m_fault) begin nerr++; $display("FAIL rnd_fault[%0d] got %b exp %b", c, fault, m_fault); end
      if (m_q.size() != 0) begin
        nvec++;
        if (out_pc !== m_q[0] || out_instr !== rom(m_q[0])) begin
          nerr++; $display("FAIL rnd_head[%0d] got pc=%h ins=%h exp pc=%h ins=%h", c, out_pc, out_instr, m_q[0], rom(m_q[0]));
        end
      end
    end
    redirect = 1'b0; start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_misaligned();
    test_oob();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, meaning instruction ROM size in bytes (power of two, >4).
REQ-002 SHALL have parameter RESET_PC, default 64'd0, meaning first fetch byte address after reset (word-aligned).
REQ-003 SHALL have parameter DEPTH, default 2, meaning fetch buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port start  input  1  leave IDLE and begin fetching.
REQ-007 SHALL have port imem_addr  output  64  byte address to combinational instruction ROM.
REQ-008 SHALL have port imem_instr  input  32  ROM read data for imem_addr, same cycle.
REQ-009 SHALL have port redirect  input  1  branch taken; flush and refetch.
REQ-010 SHALL have port redirect_pc  input  64  redirect target byte address.
REQ-011 SHALL have port out_valid  output  1  buffer head valid to decode.
REQ-012 SHALL have port out_ready  input  1  decode accepts head.
REQ-013 SHALL have port out_instr  output  32  head instruction.
REQ-014 SHALL have port out_pc  output  64  head instruction byte address.
REQ-015 SHALL have port fault  output  1  sticky fetch fault (out of bounds or misaligned).

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, FAULT; IDLE->FETCH on start; FETCH->FAULT on fault condition; FAULT exits only by reset.
REQ-017 SHALL drive imem_addr = pc register in every state.
REQ-018 SHALL push {imem_instr, pc} and set pc <= pc+4 at an edge only in FETCH, with no redirect, with pc+3 < MEM_SIZE, and with buffer not full or popped that cycle.
REQ-019 SHALL pop head when out_valid && out_ready; out_valid = (count != 0).
REQ-020 SHALL give fetch-to-out_valid latency of exactly 1 cycle (pushed entry visible the next cycle).
REQ-021 SHALL allow simultaneous push and pop when full, count unchanged.
REQ-022 SHALL, on redirect in FETCH, flush buffer (count 0), discard that cycle's fetch, ignore any pop, set pc <= redirect_pc; redirect has priority over push/pop.
REQ-023 SHALL enter FAULT, set fault=1, not update pc, when redirect_pc[1:0] != 0 at a redirect, or when pc+3 >= MEM_SIZE at a would-be push.
REQ-024 SHALL in FAULT perform no push, ignore redirect and start, still drain existing entries to out_ready.
REQ-025 SHALL ignore redirect and out_ready pops of empty buffer in IDLE; start and redirect together in IDLE: start wins, redirect ignored.
REQ-026 SHALL wrap buffer read/write pointers modulo DEPTH; count width clog2(DEPTH)+1.

Reset
REQ-027 SHALL on reset=0 asynchronously force state IDLE, pc=RESET_PC, count=0, pointers 0, fault=0, out_valid=0.
REQ-028 SHALL, on reset mid-operation, discard buffered entries; out_instr/out_pc are don't-care while out_valid=0.

Structure
REQ-029 SHALL place state enum (IDLE, FETCH, FAULT) and defaults MEM_SIZE/RESET_PC in shared package fetch_pkg.
REQ-030 SHALL implement the buffer as sub-module fetch_fifo (DEPTH-entry, 96-bit, push/pop/flush/full/empty).

Verification
REQ-031 SHALL cover: reset, start, out_ready=1 constant -> out_pc 0,4,8,... one per cycle from cycle after first fetch, instructions match ROM words.
REQ-032 SHALL cover: out_ready=0 for 5 cycles after start -> 2 entries held (pc 0,4), imem_addr stalls at 8; release -> 0,4,8 in order, no loss/duplication.
REQ-033 SHALL cover: redirect to 0x40 while buffer full -> next cycle out_valid=0, then out_pc=0x40, 0x44.
REQ-034 SHALL cover: redirect_pc=0x42 -> fault=1 next cycle, no further pushes, fault stays 1 until reset.
REQ-035 SHALL cover: redirect to 0x3FC, out_ready=1 -> out_pc 0x3FC delivered, then fault=1 at pc 0x400, no push of 0x400.
REQ-036 SHALL cover: reset=0 asserted mid-FETCH between edges -> out_valid, fault drop immediately, imem_addr=RESET_PC.
